// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch/issue stage: RV32I base opcodes, the NOP
// encoding and the fetch FSM state encoding.
package inst_fetch_pkg;

  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] JALR   = 7'h67;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fields.sv
// Splits a 32-bit RISC-V instruction word into its fixed-position fields.
// Purely combinational; shared with the decoder.
module inst_fields (
  input  logic [31:0] i_inst,
  output logic [6:0]  o_opcode,
  output logic [4:0]  o_rd,
  output logic [2:0]  o_funct3,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [6:0]  o_funct7
);

  assign o_opcode = i_inst[6:0];
  assign o_rd     = i_inst[11:7];
  assign o_funct3 = i_inst[14:12];
  assign o_rs1    = i_inst[19:15];
  assign o_rs2    = i_inst[24:20];
  assign o_funct7 = i_inst[31:25];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch/issue stage: req/ack fetch from instruction memory, one
// registered instruction presented over valid/ready, PC redirect with squash.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             nreset,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [XLEN-1:0]  inst_pc,
  output logic [6:0]       opcode,
  output logic [4:0]       rd,
  output logic [2:0]       funct3,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [6:0]       funct7,
  input  logic             pc_load,
  input  logic [XLEN-1:0]  pc_load_addr
);

  fetch_state_e    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_discard, w_discard_nxt;
  logic            r_req, w_req_nxt;
  logic [XLEN-1:0] r_addr, w_addr_nxt;
  logic            r_valid, w_valid_nxt;
  logic [31:0]     r_inst, w_inst_nxt;
  logic [XLEN-1:0] r_inst_pc, w_inst_pc_nxt;
  logic [XLEN-1:0] w_target;

  assign w_target = {pc_load_addr[XLEN-1:2], 2'b00};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= S_FETCH;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: w_state_nxt = S_WAIT;
      S_WAIT:  if (imem_ack) w_state_nxt = (pc_load || r_discard) ? S_FETCH : S_ISSUE;
      S_ISSUE: if (pc_load || inst_ready) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // NOTE: every comb output gets a hold-value default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_pc_nxt      = r_pc;
    w_discard_nxt = r_discard;
    w_req_nxt     = r_req;
    w_addr_nxt    = r_addr;
    w_valid_nxt   = r_valid;
    w_inst_nxt    = r_inst;
    w_inst_pc_nxt = r_inst_pc;

    if (pc_load) w_pc_nxt = w_target;

    case (r_state)
      S_FETCH: begin
        w_req_nxt  = 1'b1;
        w_addr_nxt = pc_load ? w_target : r_pc;
      end
      S_WAIT: begin
        if (imem_ack) begin
          w_req_nxt     = 1'b0;
          w_discard_nxt = 1'b0;
          if (!pc_load && !r_discard) begin
            w_valid_nxt   = 1'b1;
            w_inst_nxt    = imem_rdata;
            w_inst_pc_nxt = r_pc;
          end
        end else if (pc_load) begin
          // Address stays on the old PC until the outstanding ack arrives.
          w_discard_nxt = 1'b1;
        end
      end
      S_ISSUE: begin
        if (pc_load || inst_ready) w_valid_nxt = 1'b0;
        if (!pc_load && inst_ready) w_pc_nxt = r_pc + XLEN'(4);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_pc      <= RESET_PC;
      r_discard <= 1'b0;
      r_req     <= 1'b0;
      r_addr    <= RESET_PC;
      r_valid   <= 1'b0;
      r_inst    <= NOP_INST;
      r_inst_pc <= RESET_PC;
    end else begin
      r_pc      <= w_pc_nxt;
      r_discard <= w_discard_nxt;
      r_req     <= w_req_nxt;
      r_addr    <= w_addr_nxt;
      r_valid   <= w_valid_nxt;
      r_inst    <= w_inst_nxt;
      r_inst_pc <= w_inst_pc_nxt;
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_addr;
  assign inst_valid = r_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;

  inst_fields u_fields (
    .i_inst   (r_inst),
    .o_opcode (opcode),
    .o_rd     (rd),
    .o_funct3 (funct3),
    .o_rs1    (rs1),
    .o_rs2    (rs2),
    .o_funct7 (funct7)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: cycle-by-cycle vector table driving the
// memory and consumer sides, plus field checks and a mid-fetch reset.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        nreset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic        pc_load;
  logic [31:0] pc_load_addr;

  inst_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .opcode       (opcode),
    .rd           (rd),
    .funct3       (funct3),
    .rs1          (rs1),
    .rs2          (rs2),
    .funct7       (funct7),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        load;
    logic [31:0] load_addr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic ack, input logic [31:0] rdata, input logic ready,
                     input logic load, input logic [31:0] load_addr,
                     input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                     input logic [31:0] e_inst, input logic [31:0] e_pc);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready; v.load = load; v.load_addr = load_addr;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_inst = e_inst; v.e_pc = e_pc;
    vq.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_inst, input logic [31:0] e_pc);
    check({tag, "_req"},   {31'd0, imem_req},   {31'd0, e_req});
    check({tag, "_addr"},  imem_addr,           e_addr);
    check({tag, "_valid"}, {31'd0, inst_valid}, {31'd0, e_valid});
    check({tag, "_inst"},  inst,                e_inst);
    check({tag, "_pc"},    inst_pc,             e_pc);
  endtask

  initial begin
    nreset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    pc_load = 1'b0; pc_load_addr = '0;

    // Stimulus/expectation table: inputs held for one cycle, outputs after the edge.
    add(0, 32'h0, 0, 0, 32'h0,        1, 32'h0,   0, NOP,          32'h0);   // 0 first req
    add(0, 32'h0, 0, 0, 32'h0,        1, 32'h0,   0, NOP,          32'h0);
    add(1, 32'h0020_81B3, 0, 0, 32'h0, 0, 32'h0,  1, 32'h0020_81B3, 32'h0);  // 2 issue
    add(0, 32'h0, 1, 0, 32'h0,        0, 32'h0,   0, 32'h0020_81B3, 32'h0);
    add(0, 32'h0, 0, 0, 32'h0,        1, 32'h4,   0, 32'h0020_81B3, 32'h0);  // 4 next at +4
    add(0, 32'h0, 0, 0, 32'h0,        1, 32'h4,   0, 32'h0020_81B3, 32'h0);
    add(1, 32'h00A0_0093, 0, 0, 32'h0, 0, 32'h4,  1, 32'h00A0_0093, 32'h4);
    add(1, 32'hFFFF_FFFF, 0, 0, 32'h0, 0, 32'h4,  1, 32'h00A0_0093, 32'h4);  // 7 ack in ISSUE ignored
    add(0, 32'h0, 1, 1, 32'h200,      0, 32'h4,   0, 32'h00A0_0093, 32'h4);  // 8 squash + redirect
    add(0, 32'h0, 0, 0, 32'h0,        1, 32'h200, 0, 32'h00A0_0093, 32'h4);
    add(1, 32'h0000_006F, 0, 0, 32'h0, 0, 32'h200, 1, 32'h0000_006F, 32'h200);
    add(0, 32'h0, 1, 0, 32'h0,        0, 32'h200, 0, 32'h0000_006F, 32'h200);
    add(0, 32'h0, 0, 0, 32'h0,        1, 32'h204, 0, 32'h0000_006F, 32'h200);
    add(0, 32'h0, 0, 1, 32'h103,      1, 32'h204, 0, 32'h0000_006F, 32'h200); // 13 redirect in WAIT
    add(0, 32'h0, 0, 0, 32'h0,        1, 32'h204, 0, 32'h0000_006F, 32'h200);
    add(0, 32'h0, 0, 0, 32'h0,        1, 32'h204, 0, 32'h0000_006F, 32'h200);
    add(1, 32'hDEAD_BEEF, 0, 0, 32'h0, 0, 32'h204, 0, 32'h0000_006F, 32'h200); // 16 dropped
    add(0, 32'h0, 0, 0, 32'h0,        1, 32'h100, 0, 32'h0000_006F, 32'h200);
    add(1, 32'h4020_8033, 0, 0, 32'h0, 0, 32'h100, 1, 32'h4020_8033, 32'h100);
    add(0, 32'h0, 1, 0, 32'h0,        0, 32'h100, 0, 32'h4020_8033, 32'h100);
    add(0, 32'h0, 0, 0, 32'h0,        1, 32'h104, 0, 32'h4020_8033, 32'h100);
    add(1, 32'h1111_1111, 0, 1, 32'h300, 0, 32'h104, 0, 32'h4020_8033, 32'h100); // 21 ack + redirect
    add(0, 32'h0, 0, 0, 32'h0,        1, 32'h300, 0, 32'h4020_8033, 32'h100);
    add(1, 32'h00C5_8533, 0, 0, 32'h0, 0, 32'h300, 1, 32'h00C5_8533, 32'h300);
    add(0, 32'h0, 1, 0, 32'h0,        0, 32'h300, 0, 32'h00C5_8533, 32'h300);
    add(0, 32'h0, 0, 0, 32'h0,        1, 32'h304, 0, 32'h00C5_8533, 32'h300);
    add(0, 32'h0, 0, 1, 32'h400,      1, 32'h304, 0, 32'h00C5_8533, 32'h300); // 26 repeated redirect
    add(0, 32'h0, 0, 1, 32'h507,      1, 32'h304, 0, 32'h00C5_8533, 32'h300);
    add(1, 32'hAAAA_AAAA, 0, 0, 32'h0, 0, 32'h304, 0, 32'h00C5_8533, 32'h300);
    add(0, 32'h0, 0, 0, 32'h0,        1, 32'h504, 0, 32'h00C5_8533, 32'h300);
    add(1, 32'h0000_0073, 0, 0, 32'h0, 0, 32'h504, 1, 32'h0000_0073, 32'h504);
    add(0, 32'h0, 1, 0, 32'h0,        0, 32'h504, 0, 32'h0000_0073, 32'h504);
    add(0, 32'h0, 0, 1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFC, 0, 32'h0000_0073, 32'h504); // 32 redirect in FETCH
    add(1, 32'h0010_0093, 0, 0, 32'h0, 0, 32'hFFFF_FFFC, 1, 32'h0010_0093, 32'hFFFF_FFFC);
    add(0, 32'h0, 1, 0, 32'h0,        0, 32'hFFFF_FFFC, 0, 32'h0010_0093, 32'hFFFF_FFFC);
    add(0, 32'h0, 0, 0, 32'h0,        1, 32'h0,   0, 32'h0010_0093, 32'hFFFF_FFFC); // 35 wrap
    add(1, 32'h0020_8133, 0, 0, 32'h0, 0, 32'h0,  1, 32'h0020_8133, 32'h0);
    for (int k = 0; k < 5; k++)
      add(0, 32'h0, 0, 0, 32'h0,      0, 32'h0,   1, 32'h0020_8133, 32'h0);  // 37..41 stall
    add(0, 32'h0, 1, 0, 32'h0,        0, 32'h0,   0, 32'h0020_8133, 32'h0);
    add(0, 32'h0, 0, 0, 32'h0,        1, 32'h4,   0, 32'h0020_8133, 32'h0);  // 43 now in WAIT

    #3 nreset = 1'b0;
    #1 check_outputs("reset", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
    check("reset_opcode", {25'd0, opcode}, 32'h13);
    check("reset_rd",     {27'd0, rd},     32'h0);

    @(negedge clk) nreset = 1'b1;

    foreach (vq[i]) begin
      imem_ack     = vq[i].ack;
      imem_rdata   = vq[i].rdata;
      inst_ready   = vq[i].ready;
      pc_load      = vq[i].load;
      pc_load_addr = vq[i].load_addr;
      @(posedge clk);
      #1;
      check_outputs($sformatf("v%0d", i), vq[i].e_req, vq[i].e_addr,
                    vq[i].e_valid, vq[i].e_inst, vq[i].e_pc);
      if (i == 2) begin
        check("v2_opcode", {25'd0, opcode}, 32'h33);
        check("v2_rd",     {27'd0, rd},     32'd3);
        check("v2_funct3", {29'd0, funct3}, 32'd0);
        check("v2_rs1",    {27'd0, rs1},    32'd1);
        check("v2_rs2",    {27'd0, rs2},    32'd2);
        check("v2_funct7", {25'd0, funct7}, 32'd0);
      end
      if (i == 18) begin
        check("v18_opcode", {25'd0, opcode}, 32'h33);
        check("v18_rd",     {27'd0, rd},     32'd0);
        check("v18_rs1",    {27'd0, rs1},    32'd1);
        check("v18_rs2",    {27'd0, rs2},    32'd2);
        check("v18_funct7", {25'd0, funct7}, 32'h20);
      end
    end

    imem_ack = 1'b0; inst_ready = 1'b0; pc_load = 1'b0; pc_load_addr = '0;

    // Reset pulsed while a fetch is outstanding: outputs clear without a clock edge.
    #2 nreset = 1'b0;
    #1 check_outputs("midreset", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
    check("midreset_opcode", {25'd0, opcode}, 32'h13);
    @(negedge clk) nreset = 1'b1;
    @(posedge clk);
    #1 check_outputs("restart", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h0030_0113;
    @(posedge clk);
    #1 check_outputs("restart_issue", 1'b0, 32'h0, 1'b1, 32'h0030_0113, 32'h0);
    imem_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
